writeback: RTL and testbench
============================

WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 Parameter: N, default 64, datapath width in bits.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous, active-low reset; clears all state immediately on assertion.
REQ-004 stall_W  input  1  hold the MEM/WB register contents.
REQ-005 flush_W  input  1  invalidate the MEM/WB register at the next edge.
REQ-006 valid_M  input  1  the memory-stage instruction is real (not a bubble).
REQ-007 regWrite_M, memToReg_M  input  1 each  memory-stage control bits.
REQ-008 aluResult_M, readData_M  input  N each  ALU result and data-memory load data.
REQ-009 wa3_M  input  5  destination register of the memory-stage instruction.
REQ-010 ra1_D, ra2_D  input  5 each  decode-stage read addresses.
REQ-011 rd1_D, rd2_D  input  N each  raw register-file read data.
REQ-012 regWrite_D  output  1  register-file write enable toward decode.
REQ-013 wa3_D  output  5  register-file write address toward decode.
REQ-014 writeData3_D  output  N  register-file write data toward decode.
REQ-015 fwd1_D, fwd2_D  output  N each  bypassed read data for decode.
REQ-016 retired_W  output  32  count of instructions that left writeback.

Function
REQ-017 State: MEM/WB register fields valid_W, regWrite_W, memToReg_W, aluResult_W, readData_W, wa3_W, plus a written_W flag and a retired_W counter.
REQ-018 Capture: on each rising edge with flush_W=0 and stall_W=0, the block SHALL load every *_M input into the matching *_W field and clear written_W.
REQ-019 Stall: on an edge with stall_W=1 and flush_W=0, the block SHALL hold all *_W fields and set written_W=1 when regWrite_D was 1 in that cycle.
REQ-020 Flush: on an edge with flush_W=1, the block SHALL clear valid_W and written_W; flush overrides stall.
REQ-021 writeData3_D SHALL be readData_W when memToReg_W=1, else aluResult_W; it is combinational from registered state with zero added latency.
REQ-022 wa3_D SHALL equal wa3_W.
REQ-023 Pending-write condition: wb_pend = valid_W and regWrite_W and (wa3_W != 31).
REQ-024 regWrite_D SHALL equal wb_pend and not written_W, so each instruction writes the register file exactly once, including under multi-cycle stall.
REQ-025 X31 (XZR): writes to register 31 SHALL never assert regWrite_D and SHALL never be bypassed.
REQ-026 Bypass: fwd1_D SHALL be writeData3_D when wb_pend=1 and ra1_D=wa3_W, else rd1_D; fwd2_D uses the same rule with ra2_D and rd2_D. This rule is independent of written_W.
REQ-027 Retire: on an edge with valid_W=1, stall_W=0 and flush_W=0, retired_W SHALL increment by 1, wrapping from 0xFFFFFFFF to 0.
REQ-028 A bubble (valid_M=0) SHALL propagate as valid_W=0 and produce no write, no bypass and no count.

Reset
REQ-029 While reset_n=0, the block SHALL hold valid_W, regWrite_W, memToReg_W, written_W=0; aluResult_W, readData_W=0; wa3_W=0; retired_W=0.
REQ-030 During and after reset, until the first capture, outputs SHALL be regWrite_D=0, wa3_D=0, writeData3_D=0, fwd1_D=rd1_D and fwd2_D=rd2_D.
REQ-031 Reset asserted mid-stall SHALL discard the held instruction with no further write.

Verification
REQ-032 ALU op: valid_M=1, regWrite_M=1, memToReg_M=0, aluResult_M=0x2A, wa3_M=5, one edge -> regWrite_D=1, wa3_D=5, writeData3_D=0x2A, retired_W increments on the next edge.
REQ-033 Load plus bypass: memToReg_M=1, readData_M=0xDEAD, wa3_M=3; then ra1_D=3, rd1_D=0 -> fwd1_D=0xDEAD; with ra2_D=4 -> fwd2_D=rd2_D.
REQ-034 XZR: wa3_M=31, regWrite_M=1, ra1_D=31 -> regWrite_D=0 and fwd1_D=rd1_D.
REQ-035 Stall 3 cycles after capture -> regWrite_D=1 in the first cycle only, data held, retired_W unchanged until stall_W drops.
REQ-036 flush_W=1 together with stall_W=1 -> valid_W=0 next cycle, regWrite_D=0, no count.
REQ-037 Counter preloaded near 0xFFFFFFFF by retiring 2 instructions across wrap -> 0xFFFFFFFF then 0x00000000; reset_n pulse mid-stall -> all outputs per REQ-030 immediately.

Source files
------------

// File: rtl/writeback.sv
// Writeback stage: MEM/WB pipeline register, single-shot register-file write,
// WB->decode bypass and a retired-instruction counter.
module writeback #(
    parameter int unsigned N = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         stall_W,
    input  logic         flush_W,
    input  logic         valid_M,
    input  logic         regWrite_M,
    input  logic         memToReg_M,
    input  logic [N-1:0] aluResult_M,
    input  logic [N-1:0] readData_M,
    input  logic [4:0]   wa3_M,
    input  logic [4:0]   ra1_D,
    input  logic [4:0]   ra2_D,
    input  logic [N-1:0] rd1_D,
    input  logic [N-1:0] rd2_D,
    output logic         regWrite_D,
    output logic [4:0]   wa3_D,
    output logic [N-1:0] writeData3_D,
    output logic [N-1:0] fwd1_D,
    output logic [N-1:0] fwd2_D,
    output logic [31:0]  retired_W
);

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 32;
    localparam logic [AW-1:0] XZR = AW'(31);

    typedef struct packed {
        logic          valid;
        logic          reg_write;
        logic          mem_to_reg;
        logic [N-1:0]  alu_result;
        logic [N-1:0]  read_data;
        logic [AW-1:0] wa3;
    } memwb_t;

    memwb_t        memwb_q, memwb_d;
    logic          written_q, written_d;
    logic [CW-1:0] retired_q, retired_d;
    logic          wb_pend_c;
    logic [N-1:0]  wd_c;

    // Register-file write/bypass view of the MEM/WB contents
    always_comb begin
        wb_pend_c    = memwb_q.valid & memwb_q.reg_write & (memwb_q.wa3 != XZR);
        wd_c         = memwb_q.mem_to_reg ? memwb_q.read_data : memwb_q.alu_result;
        regWrite_D   = wb_pend_c & ~written_q;
        wa3_D        = memwb_q.wa3;
        writeData3_D = wd_c;
        fwd1_D       = (wb_pend_c && (ra1_D == memwb_q.wa3)) ? wd_c : rd1_D;
        fwd2_D       = (wb_pend_c && (ra2_D == memwb_q.wa3)) ? wd_c : rd2_D;
        retired_W    = retired_q;
    end

    // Next state: flush beats stall beats capture; written_d remembers a write
    // already issued while the instruction is held.
    always_comb begin
        memwb_d   = memwb_q;
        written_d = written_q;
        retired_d = retired_q + CW'(memwb_q.valid & ~stall_W & ~flush_W);
        if (flush_W) begin
            memwb_d.valid = 1'b0;
            written_d     = 1'b0;
        end else if (stall_W) begin
            written_d = written_q | regWrite_D;
        end else begin
            memwb_d.valid      = valid_M;
            memwb_d.reg_write  = regWrite_M;
            memwb_d.mem_to_reg = memToReg_M;
            memwb_d.alu_result = aluResult_M;
            memwb_d.read_data  = readData_M;
            memwb_d.wa3        = wa3_M;
            written_d          = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            memwb_q   <= '0;
            written_q <= 1'b0;
            retired_q <= '0;
        end else begin
            memwb_q   <= memwb_d;
            written_q <= written_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: scoreboard of expected register-file
// writes plus a small valid/retire model.
module tb_writeback;

    localparam int unsigned N = 64;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         stall_W, flush_W, valid_M, regWrite_M, memToReg_M;
    logic [N-1:0] aluResult_M, readData_M, rd1_D, rd2_D;
    logic [4:0]   wa3_M, ra1_D, ra2_D;
    logic         regWrite_D;
    logic [4:0]   wa3_D;
    logic [N-1:0] writeData3_D, fwd1_D, fwd2_D;
    logic [31:0]  retired_W;

    typedef struct {
        logic         we;
        logic [4:0]   wa;
        logic [N-1:0] wd;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          errors = 0;
    int          checks = 0;
    logic        model_valid;
    logic [31:0] exp_retired;

    writeback #(.N(N)) dut (
        .clk(clk), .reset_n(reset_n), .stall_W(stall_W), .flush_W(flush_W),
        .valid_M(valid_M), .regWrite_M(regWrite_M), .memToReg_M(memToReg_M),
        .aluResult_M(aluResult_M), .readData_M(readData_M), .wa3_M(wa3_M),
        .ra1_D(ra1_D), .ra2_D(ra2_D), .rd1_D(rd1_D), .rd2_D(rd2_D),
        .regWrite_D(regWrite_D), .wa3_D(wa3_D), .writeData3_D(writeData3_D),
        .fwd1_D(fwd1_D), .fwd2_D(fwd2_D), .retired_W(retired_W)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    // Drive a memory-stage instruction and record the write it should produce
    task automatic drive_m(input logic v, input logic rw, input logic m2r,
                           input logic [N-1:0] alu, input logic [N-1:0] rd,
                           input logic [4:0] wa);
        exp_t x;
        valid_M = v; regWrite_M = rw; memToReg_M = m2r;
        aluResult_M = alu; readData_M = rd; wa3_M = wa;
        x.we = v & rw & (wa != 5'd31);
        x.wa = wa;
        x.wd = m2r ? rd : alu;
        sb.push_back(x);
    endtask

    // One clock edge; inputs are changed and outputs sampled 1 time unit after it
    task automatic step();
        logic ret;
        ret = model_valid & ~stall_W & ~flush_W;
        if (flush_W) model_valid = 1'b0;
        else if (!stall_W) model_valid = valid_M;
        @(posedge clk);
        #1;
        if (ret) exp_retired = exp_retired + 32'd1;
    endtask

    task automatic pop_exp(input string name);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty", name);
            e.we = 1'b0; e.wa = '0; e.wd = '0;
        end else begin
            e = sb.pop_front();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        stall_W = 0; flush_W = 0; valid_M = 0; regWrite_M = 0; memToReg_M = 0;
        aluResult_M = '0; readData_M = '0; wa3_M = '0;
        ra1_D = 5'd0; ra2_D = 5'd0;
        rd1_D = {$urandom, $urandom}; rd2_D = {$urandom, $urandom};
        model_valid = 1'b0; exp_retired = 32'd0;
        #3;
        checks++; if (regWrite_D !== 1'b0) begin errors++; $display("FAIL reset_we got %0b exp 0", regWrite_D); end
        checks++; if (wa3_D !== 5'd0) begin errors++; $display("FAIL reset_wa got %0d exp 0", wa3_D); end
        checks++; if (writeData3_D !== '0) begin errors++; $display("FAIL reset_wd got %0h exp 0", writeData3_D); end
        checks++; if (fwd1_D !== rd1_D) begin errors++; $display("FAIL reset_fwd1 got %0h exp %0h", fwd1_D, rd1_D); end
        checks++; if (fwd2_D !== rd2_D) begin errors++; $display("FAIL reset_fwd2 got %0h exp %0h", fwd2_D, rd2_D); end
        checks++; if (retired_W !== 32'd0) begin errors++; $display("FAIL reset_ret got %0h exp 0", retired_W); end
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_alu_op();
        drive_m(1'b1, 1'b1, 1'b0, N'(64'h2A), N'(64'h99), 5'd5);
        step();
        pop_exp("alu");
        checks++; if (regWrite_D !== e.we) begin errors++; $display("FAIL alu_we got %0b exp %0b", regWrite_D, e.we); end
        checks++; if (wa3_D !== e.wa) begin errors++; $display("FAIL alu_wa got %0d exp %0d", wa3_D, e.wa); end
        checks++; if (writeData3_D !== e.wd) begin errors++; $display("FAIL alu_wd got %0h exp %0h", writeData3_D, e.wd); end
        checks++; if (retired_W !== exp_retired) begin errors++; $display("FAIL alu_ret0 got %0h exp %0h", retired_W, exp_retired); end
        drive_m(1'b0, 1'b1, 1'b0, N'(64'h7), N'(64'h8), 5'd6);
        step();
        pop_exp("alu_bubble");
        checks++; if (regWrite_D !== e.we) begin errors++; $display("FAIL bubble_we got %0b exp %0b", regWrite_D, e.we); end
        checks++; if (retired_W !== exp_retired) begin errors++; $display("FAIL alu_ret1 got %0h exp %0h", retired_W, exp_retired); end
    endtask

    task automatic test_load_bypass();
        drive_m(1'b1, 1'b1, 1'b1, N'(64'h1111), N'(64'hDEAD), 5'd3);
        step();
        pop_exp("load");
        checks++; if (writeData3_D !== e.wd) begin errors++; $display("FAIL load_wd got %0h exp %0h", writeData3_D, e.wd); end
        ra1_D = 5'd3; rd1_D = '0; ra2_D = 5'd4; rd2_D = N'(64'h5555);
        #1;
        checks++; if (fwd1_D !== N'(64'hDEAD)) begin errors++; $display("FAIL byp_fwd1 got %0h exp dead", fwd1_D); end
        checks++; if (fwd2_D !== N'(64'h5555)) begin errors++; $display("FAIL byp_fwd2 got %0h exp 5555", fwd2_D); end
        ra2_D = 5'd3;
        #1;
        checks++; if (fwd2_D !== N'(64'hDEAD)) begin errors++; $display("FAIL byp_fwd2_hit got %0h exp dead", fwd2_D); end
    endtask

    task automatic test_xzr();
        drive_m(1'b1, 1'b1, 1'b0, N'(64'h77), N'(64'h0), 5'd31);
        step();
        pop_exp("xzr");
        ra1_D = 5'd31; rd1_D = N'(64'h1234);
        #1;
        checks++; if (regWrite_D !== e.we) begin errors++; $display("FAIL xzr_we got %0b exp %0b", regWrite_D, e.we); end
        checks++; if (fwd1_D !== N'(64'h1234)) begin errors++; $display("FAIL xzr_fwd1 got %0h exp 1234", fwd1_D); end
    endtask

    task automatic test_stall();
        logic [31:0] ret_before;
        drive_m(1'b1, 1'b1, 1'b0, N'(64'hBEEF), N'(64'h0), 5'd7);
        step();
        pop_exp("stall_cap");
        stall_W = 1'b1;
        valid_M = 1'b1; wa3_M = 5'd9; aluResult_M = N'(64'h999);
        ra1_D = 5'd7; rd1_D = N'(64'h1);
        #1;
        checks++; if (regWrite_D !== e.we) begin errors++; $display("FAIL stall_we0 got %0b exp %0b", regWrite_D, e.we); end
        ret_before = exp_retired;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (regWrite_D !== 1'b0) begin errors++; $display("FAIL stall_we%0d got %0b exp 0", i + 1, regWrite_D); end
            checks++; if (writeData3_D !== N'(64'hBEEF) || wa3_D !== 5'd7) begin errors++; $display("FAIL stall_hold%0d got %0h/%0d exp beef/7", i + 1, writeData3_D, wa3_D); end
            checks++; if (fwd1_D !== N'(64'hBEEF)) begin errors++; $display("FAIL stall_fwd%0d got %0h exp beef", i + 1, fwd1_D); end
            checks++; if (retired_W !== ret_before) begin errors++; $display("FAIL stall_ret%0d got %0h exp %0h", i + 1, retired_W, ret_before); end
        end
        stall_W = 1'b0;
        drive_m(1'b0, 1'b0, 1'b0, N'(64'h0), N'(64'h0), 5'd0);
        step();
        pop_exp("stall_release");
        checks++; if (regWrite_D !== e.we) begin errors++; $display("FAIL stall_rel_we got %0b exp %0b", regWrite_D, e.we); end
        checks++; if (retired_W !== ret_before + 32'd1) begin errors++; $display("FAIL stall_rel_ret got %0h exp %0h", retired_W, ret_before + 32'd1); end
    endtask

    task automatic test_flush_stall();
        drive_m(1'b1, 1'b1, 1'b0, N'(64'hF00D), N'(64'h0), 5'd10);
        step();
        pop_exp("flush_cap");
        checks++; if (regWrite_D !== e.we) begin errors++; $display("FAIL flush_cap_we got %0b exp %0b", regWrite_D, e.we); end
        stall_W = 1'b1; flush_W = 1'b1;
        ra1_D = 5'd10; rd1_D = N'(64'hAB);
        step();
        checks++; if (regWrite_D !== 1'b0) begin errors++; $display("FAIL flush_we got %0b exp 0", regWrite_D); end
        checks++; if (fwd1_D !== N'(64'hAB)) begin errors++; $display("FAIL flush_fwd1 got %0h exp ab", fwd1_D); end
        checks++; if (retired_W !== exp_retired) begin errors++; $display("FAIL flush_ret got %0h exp %0h", retired_W, exp_retired); end
        stall_W = 1'b0; flush_W = 1'b0;
        drive_m(1'b0, 1'b0, 1'b0, N'(64'h0), N'(64'h0), 5'd0);
        step();
        pop_exp("flush_after");
        checks++; if (retired_W !== exp_retired) begin errors++; $display("FAIL flush_ret2 got %0h exp %0h", retired_W, exp_retired); end
    endtask

    task automatic test_back_to_back();
        logic         v, rw, m2r;
        logic [N-1:0] alu, rd;
        logic [4:0]   wa;
        for (int i = 0; i < 10; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            rw  = ($urandom_range(0, 3) != 0);
            m2r = 1'($urandom_range(0, 1));
            alu = {$urandom, $urandom};
            rd  = {$urandom, $urandom};
            wa  = 5'($urandom_range(0, 31));
            drive_m(v, rw, m2r, alu, rd, wa);
            step();
            pop_exp("b2b");
            checks++; if (regWrite_D !== e.we || wa3_D !== e.wa || writeData3_D !== e.wd) begin
                errors++;
                $display("FAIL b2b_%0d got we=%0b wa=%0d wd=%0h exp we=%0b wa=%0d wd=%0h",
                         i, regWrite_D, wa3_D, writeData3_D, e.we, e.wa, e.wd);
            end
            checks++; if (retired_W !== exp_retired) begin errors++; $display("FAIL b2b_ret_%0d got %0h exp %0h", i, retired_W, exp_retired); end
        end
    endtask

    task automatic test_wrap();
        drive_m(1'b1, 1'b1, 1'b0, N'(64'h1), N'(64'h0), 5'd1);
        step();
        pop_exp("wrap_a");
        stall_W = 1'b1;
        force dut.retired_q = 32'hFFFF_FFFE;
        exp_retired = 32'hFFFF_FFFE;
        step();
        release dut.retired_q;
        #1;
        checks++; if (retired_W !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_pre got %0h exp fffffffe", retired_W); end
        stall_W = 1'b0;
        drive_m(1'b1, 1'b1, 1'b0, N'(64'h2), N'(64'h0), 5'd2);
        step();
        pop_exp("wrap_b");
        checks++; if (retired_W !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_max got %0h exp ffffffff", retired_W); end
        drive_m(1'b0, 1'b0, 1'b0, N'(64'h0), N'(64'h0), 5'd0);
        step();
        pop_exp("wrap_c");
        checks++; if (retired_W !== 32'h0 || exp_retired !== 32'h0) begin errors++; $display("FAIL wrap_zero got %0h exp 0", retired_W); end
    endtask

    task automatic test_reset_mid_stall();
        drive_m(1'b1, 1'b1, 1'b0, N'(64'h55), N'(64'h0), 5'd12);
        step();
        pop_exp("rst_cap");
        stall_W = 1'b1;
        step();
        ra1_D = 5'd12; rd1_D = N'(64'hC0DE); ra2_D = 5'd12; rd2_D = N'(64'hFACE);
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (regWrite_D !== 1'b0 || wa3_D !== 5'd0 || writeData3_D !== '0) begin
            errors++;
            $display("FAIL rst_mid_out got we=%0b wa=%0d wd=%0h exp 0/0/0", regWrite_D, wa3_D, writeData3_D);
        end
        checks++; if (fwd1_D !== N'(64'hC0DE) || fwd2_D !== N'(64'hFACE)) begin errors++; $display("FAIL rst_mid_fwd got %0h/%0h exp c0de/face", fwd1_D, fwd2_D); end
        checks++; if (retired_W !== 32'd0) begin errors++; $display("FAIL rst_mid_ret got %0h exp 0", retired_W); end
        stall_W = 1'b0; valid_M = 1'b0;
        sb.delete();
        model_valid = 1'b0; exp_retired = 32'd0;
        @(negedge clk);
        reset_n = 1'b1;
        step();
        checks++; if (regWrite_D !== 1'b0 || retired_W !== exp_retired) begin errors++; $display("FAIL rst_after got we=%0b ret=%0h exp 0/%0h", regWrite_D, retired_W, exp_retired); end
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_load_bypass();
        test_xzr();
        test_stall();
        test_flush_stall();
        test_back_to_back();
        test_wrap();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
